// File: rtl/apb_master_engine.sv
// apb_master_engine: APB3 master stage of the AXI2APB bridge.
// Runs each burst beat as SETUP/ACCESS and reports completion upstream.
module apb_master_engine #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_trans_i,
    input  logic                  rd_trans_i,
    input  logic [ADDR_WIDTH-1:0] trans_addr_i,
    input  logic [3:0]            burst_len_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  trans_done_o,
    output logic                  trans_error_o,
    output logic                  busy_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WFETCH,
        SETUP,
        ACCESS,
        COMPLETE
    } state_t;

    state_t state, state_nxt;

    logic                  wr_q, rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q, beat_q;
    logic [WW-1:0]         wait_q;
    logic                  err_acc_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q, rdata_q;
    logic                  error_q;

    logic                  start_rd, start_wr;
    logic                  timeout, beat_end, last_beat, beat_err;
    logic [DATA_WIDTH-1:0] beat_data;

    assign start_rd  = rd_trans_i & ~rd_q;
    assign start_wr  = wr_trans_i & ~wr_q;
    assign timeout   = (wait_q == WAIT_MAX);
    assign beat_end  = (state == ACCESS) && (pready_i || timeout);
    assign last_beat = (beat_q == len_q);
    // A timed-out beat reports an error with zero data
    assign beat_err  = pready_i ? pslverr_i : 1'b1;
    assign beat_data = pready_i ? prdata_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_rd)      state_nxt = SETUP;
                else if (start_wr) state_nxt = WFETCH;
            end
            WFETCH:   if (!fifo_empty_i) state_nxt = SETUP;
            SETUP:    state_nxt = ACCESS;
            ACCESS:   if (beat_end) state_nxt = COMPLETE;
            COMPLETE: begin
                if (last_beat)     state_nxt = IDLE;
                else if (pwrite_q) state_nxt = WFETCH;
                else               state_nxt = SETUP;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        psel_o       = (state == SETUP) || (state == ACCESS);
        penable_o    = (state == ACCESS);
        fifo_rden_o  = (state == WFETCH) && !fifo_empty_i;
        trans_done_o = (state == COMPLETE) && (!pwrite_q || last_beat);
        busy_o       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
            err_acc_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            wr_q <= wr_trans_i;
            rd_q <= rd_trans_i;
            unique case (state)
                IDLE: begin
                    if (start_rd || start_wr) begin
                        addr_q    <= trans_addr_i;
                        len_q     <= burst_len_i;
                        beat_q    <= '0;
                        err_acc_q <= 1'b0;
                        pwrite_q  <= ~start_rd;
                    end
                end
                WFETCH: if (!fifo_empty_i) pwdata_q <= fifo_rdata_i;
                ACCESS: begin
                    if (beat_end) begin
                        wait_q <= '0;
                        if (!pwrite_q) begin
                            rdata_q <= beat_data;
                            error_q <= beat_err;
                        end else begin
                            err_acc_q <= err_acc_q | beat_err;
                            if (last_beat) begin
                                rdata_q <= '0;
                                error_q <= err_acc_q | beat_err;
                            end
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                COMPLETE: begin
                    if (!last_beat) begin
                        addr_q <= addr_q + ADDR_WIDTH'(4);
                        beat_q <= beat_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pwrite_o      = pwrite_q;
    assign paddr_o       = addr_q;
    assign pwdata_o      = pwdata_q;
    assign read_data_o   = rdata_q;
    assign trans_error_o = error_q;

endmodule

// File: tb/tb_apb_master_engine.sv
// tb_apb_master_engine: self-checking bench for apb_master_engine.
// Directed table, corner sequences and random bursts against a burst-level model.
module tb_apb_master_engine;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_trans_i = 1'b0;
    logic        rd_trans_i = 1'b0;
    logic [31:0] trans_addr_i = '0;
    logic [3:0]  burst_len_i = '0;
    logic [31:0] fifo_rdata_i = '0;
    logic        fifo_empty_i = 1'b1;
    logic        fifo_rden_o;
    logic [31:0] read_data_o;
    logic        trans_done_o, trans_error_o, busy_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o, pwdata_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;

    always #5 clk = ~clk;

    apb_master_engine #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_trans_i(wr_trans_i),
        .rd_trans_i(rd_trans_i),
        .trans_addr_i(trans_addr_i),
        .burst_len_i(burst_len_i),
        .fifo_rdata_i(fifo_rdata_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_rden_o(fifo_rden_o),
        .read_data_o(read_data_o),
        .trans_done_o(trans_done_o),
        .trans_error_o(trans_error_o),
        .busy_o(busy_o),
        .psel_o(psel_o),
        .penable_o(penable_o),
        .pwrite_o(pwrite_o),
        .paddr_o(paddr_o),
        .pwdata_o(pwdata_o),
        .prdata_i(prdata_i),
        .pready_i(pready_i),
        .pslverr_i(pslverr_i)
    );

    typedef struct {
        int          w;
        bit          err;
        logic [31:0] rd;
    } beat_t;

    typedef struct {
        logic [31:0] a;
        bit          wr;
        logic [31:0] d;
    } xfer_t;

    typedef struct {
        logic [31:0] d;
        bit          e;
    } done_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        int          wbeat;
        int          wn;
        int          ebeat;
        int          exp_xfers;
        int          exp_dones;
        bit          exp_err;
        logic [31:0] exp_last;
    } vec_t;

    beat_t       plan[$];
    xfer_t       exp_x[$];
    done_t       exp_d[$];
    logic [31:0] fifo_q[$];
    logic [31:0] held_q[$];
    vec_t        vt[8];

    int          checks = 0;
    int          errors = 0;
    int          n_setup = 0;
    int          n_done = 0;
    int          n_rden = 0;
    int          acc_k = 0;
    bit          in_acc = 1'b0;
    bit          pop_pend = 1'b0;
    beat_t       cur;
    logic [31:0] last_addr = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        if (in_acc && !(psel_o && penable_o)) begin
            chk("access_len", 32'(acc_k), 32'((cur.w < TO) ? cur.w + 1 : TO));
            in_acc = 1'b0;
        end
        if (psel_o && !penable_o) begin
            chk("setup_expected", 32'(exp_x.size() != 0), 32'd1);
            if (exp_x.size() != 0) begin
                xfer_t x;
                x = exp_x.pop_front();
                chk("paddr", paddr_o, x.a);
                chk("pwrite", 32'(pwrite_o), 32'(x.wr));
                if (x.wr) chk("pwdata", pwdata_o, x.d);
            end
            if (plan.size() != 0) begin
                cur = plan.pop_front();
            end else begin
                cur.w = 0;
                cur.err = 1'b0;
                cur.rd = 32'h0;
            end
            acc_k = 0;
            n_setup++;
            last_addr = paddr_o;
        end
        if (psel_o && penable_o) begin
            in_acc = 1'b1;
            acc_k++;
        end
        if (trans_done_o) begin
            n_done++;
            chk("done_expected", 32'(exp_d.size() != 0), 32'd1);
            chk("done_psel", 32'(psel_o), 32'd0);
            if (exp_d.size() != 0) begin
                done_t d;
                d = exp_d.pop_front();
                chk("done_data", read_data_o, d.d);
                chk("done_err", 32'(trans_error_o), 32'(d.e));
            end
        end
        if (fifo_rden_o) begin
            n_rden++;
            pop_pend = 1'b1;
        end
    endtask

    // One clock: update FIFO and APB slave responses, then observe the DUT
    task automatic step();
        logic [31:0] dummy;
        @(posedge clk);
        #1;
        if (pop_pend && fifo_q.size() != 0) dummy = fifo_q.pop_front();
        pop_pend = 1'b0;
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        if (psel_o && penable_o && acc_k >= cur.w) begin
            pready_i = 1'b1;
            pslverr_i = cur.err;
            prdata_i = cur.rd;
        end else begin
            pready_i = 1'b0;
            pslverr_i = 1'b0;
            prdata_i = $urandom;
        end
        #1;
        monitor();
    endtask

    // Burst-level reference: expected transfers and completions
    task automatic prep(input bit is_rd, input logic [31:0] addr,
                        input logic [3:0] len, input bit rnd, input int wbeat,
                        input int wn, input int ebeat, input bit preload);
        bit eor;
        eor = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            beat_t p;
            xfer_t x;
            done_t d;
            logic [31:0] wd;
            bit be;
            if (b == wbeat) p.w = wn;
            else if (!rnd) p.w = 0;
            else if ($urandom_range(0, 15) == 0) p.w = TO + 2;
            else p.w = int'($urandom_range(0, 3));
            p.err = (b == ebeat) || (rnd && $urandom_range(0, 7) == 0);
            p.rd = rnd ? $urandom : (32'hDEAD_BEEF ^ 32'(b));
            wd = rnd ? $urandom : 32'(32'h11 * (b + 1));
            plan.push_back(p);
            if (!is_rd) begin
                if (preload) fifo_q.push_back(wd);
                else held_q.push_back(wd);
            end
            x.a = addr + 32'(4 * b);
            x.wr = !is_rd;
            x.d = is_rd ? 32'h0 : wd;
            exp_x.push_back(x);
            be = (p.w < TO) ? p.err : 1'b1;
            if (is_rd) begin
                d.d = (p.w < TO) ? p.rd : 32'h0;
                d.e = be;
                exp_d.push_back(d);
            end else begin
                eor |= be;
            end
        end
        if (!is_rd) begin
            done_t d;
            d.d = 32'h0;
            d.e = eor;
            exp_d.push_back(d);
        end
    endtask

    task automatic pulse(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] l);
        trans_addr_i = a;
        burst_len_i = l;
        rd_trans_i = rd;
        wr_trans_i = wr;
        step();
        rd_trans_i = 1'b0;
        wr_trans_i = 1'b0;
        trans_addr_i = $urandom;
        burst_len_i = 4'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while ((busy_o || exp_x.size() != 0) && i < bound) begin
            step();
            i++;
        end
        chk("idle_in_time", 32'(busy_o), 32'd0);
        chk("dones_pending", 32'(exp_d.size()), 32'd0);
        chk("xfers_pending", 32'(exp_x.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, d0, r0, i;
        vt[0] = '{1'b1, 1'b0, 32'h0001_F000, 4'd0, -1, 0, -1, 1, 1, 1'b0, 32'h0001_F000};
        vt[1] = '{1'b0, 1'b1, 32'h0002_F000, 4'd3, 2, 2, -1, 4, 1, 1'b0, 32'h0002_F00C};
        vt[2] = '{1'b1, 1'b0, 32'h0000_1000, 4'd1, 1, 99, 0, 2, 2, 1'b1, 32'h0000_1004};
        vt[3] = '{1'b0, 1'b1, 32'h0000_2000, 4'd2, -1, 0, 1, 3, 1, 1'b1, 32'h0000_2008};
        vt[4] = '{1'b0, 1'b1, 32'h0000_6000, 4'd0, 0, 99, -1, 1, 1, 1'b1, 32'h0000_6000};
        vt[5] = '{1'b1, 1'b0, 32'hFFFF_FFC0, 4'd15, -1, 0, -1, 16, 16, 1'b0, 32'hFFFF_FFFC};
        vt[6] = '{1'b1, 1'b0, 32'h0000_7000, 4'd2, 1, TO - 1, -1, 3, 3, 1'b0, 32'h0000_7008};
        vt[7] = '{1'b1, 1'b1, 32'h0000_8000, 4'd0, -1, 0, -1, 1, 1, 1'b0, 32'h0000_8000};

        #12;
        chk("reset_ctrl", 32'({psel_o, penable_o, pwrite_o, trans_done_o,
                                trans_error_o, busy_o, fifo_rden_o}), 32'd0);
        chk("reset_paddr", paddr_o, 32'h0);
        chk("reset_pwdata", pwdata_o, 32'h0);
        chk("reset_rdata", read_data_o, 32'h0);
        rst_n = 1'b1;
        step();

        // Zero-wait read latency
        prep(1'b1, 32'h0001_F000, 4'd0, 1'b0, -1, 0, -1, 1'b1);
        pulse(1'b1, 1'b0, 32'h0001_F000, 4'd0);
        chk("lat_setup", 32'({psel_o, penable_o}), 32'b10);
        step();
        chk("lat_access", 32'({psel_o, penable_o}), 32'b11);
        step();
        chk("lat_done", 32'({trans_done_o, psel_o}), 32'b10);
        chk("lat_data", read_data_o, 32'hDEAD_BEEF);
        step();
        chk("lat_idle", 32'({busy_o, trans_done_o}), 32'b00);
        chk("lat_hold", read_data_o, 32'hDEAD_BEEF);

        for (int v = 0; v < 8; v++) begin
            s0 = n_setup;
            d0 = n_done;
            r0 = n_rden;
            prep(vt[v].rd, vt[v].addr, vt[v].len, 1'b0, vt[v].wbeat,
                 vt[v].wn, vt[v].ebeat, 1'b1);
            pulse(vt[v].rd, vt[v].wr, vt[v].addr, vt[v].len);
            wait_idle(400);
            chk("vec_xfers", 32'(n_setup - s0), 32'(vt[v].exp_xfers));
            chk("vec_dones", 32'(n_done - d0), 32'(vt[v].exp_dones));
            chk("vec_err", 32'(trans_error_o), 32'(vt[v].exp_err));
            chk("vec_last_addr", last_addr, vt[v].exp_last);
            chk("vec_rden", 32'(n_rden - r0),
                32'(vt[v].rd ? 0 : vt[v].exp_xfers));
            step();
        end

        // Write waiting on an empty FIFO longer than the timeout
        r0 = n_rden;
        prep(1'b0, 32'h0000_4000, 4'd0, 1'b0, -1, 0, -1, 1'b0);
        pulse(1'b0, 1'b1, 32'h0000_4000, 4'd0);
        for (int k = 0; k < 20; k++) begin
            chk("wfetch_wait", 32'({psel_o, penable_o, fifo_rden_o, busy_o}), 32'b0001);
            step();
        end
        fifo_q.push_back(held_q.pop_front());
        wait_idle(100);
        chk("wfetch_rden", 32'(n_rden - r0), 32'd1);
        chk("wfetch_err", 32'(trans_error_o), 32'd0);

        // Simultaneous edges at the top of memory, then a stray edge while busy
        s0 = n_setup;
        prep(1'b1, 32'hFFFF_FFFC, 4'd1, 1'b0, -1, 0, -1, 1'b1);
        trans_addr_i = 32'hFFFF_FFFC;
        burst_len_i = 4'd1;
        rd_trans_i = 1'b1;
        wr_trans_i = 1'b1;
        step();
        chk("sim_pwrite", 32'(pwrite_o), 32'd0);
        rd_trans_i = 1'b0;
        step();
        rd_trans_i = 1'b1;
        wait_idle(100);
        repeat (5) step();
        chk("sim_no_restart", 32'(busy_o), 32'd0);
        chk("sim_xfers", 32'(n_setup - s0), 32'd2);
        rd_trans_i = 1'b0;
        wr_trans_i = 1'b0;
        step();

        // Reset in the middle of an ACCESS phase
        prep(1'b0, 32'h0000_5000, 4'd3, 1'b0, 0, 8, -1, 1'b1);
        pulse(1'b0, 1'b1, 32'h0000_5000, 4'd3);
        i = 0;
        while (!penable_o && i < 20) begin
            step();
            i++;
        end
        chk("rst_in_access", 32'(penable_o), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_apb", 32'({psel_o, penable_o}), 32'b00);
        chk("rst_done", 32'({trans_done_o, fifo_rden_o}), 32'b00);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rdata", read_data_o, 32'h0);
        plan.delete();
        exp_x.delete();
        exp_d.delete();
        fifo_q.delete();
        in_acc = 1'b0;
        pop_pend = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_idle", 32'(busy_o), 32'd0);
        r0 = n_rden;
        prep(1'b0, 32'h0000_9000, 4'd1, 1'b0, -1, 0, -1, 1'b1);
        pulse(1'b0, 1'b1, 32'h0000_9000, 4'd1);
        wait_idle(100);
        chk("rst_restart_rden", 32'(n_rden - r0), 32'd2);

        // Random bursts
        for (int n = 0; n < 40; n++) begin
            bit          isr;
            logic [31:0] a;
            logic [3:0]  l;
            isr = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
            l = 4'($urandom);
            r0 = n_rden;
            prep(isr, a, l, 1'b1, -1, 0, -1, 1'b1);
            pulse(isr, !isr || 1'($urandom), a, l);
            wait_idle(600);
            chk("rand_rden", 32'(n_rden - r0), 32'(isr ? 0 : int'(l) + 1));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
